// File: rtl/i2c_master_controller.sv
// i2c_master_controller: byte-level I2C master sequencer.
// Drives open-drain SCL/SDA enables from the APB command registers.
module i2c_master_controller #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  pclk_i,
  input  logic                  preset_ni,
  input  logic [7:0]            reg_command_i,
  input  logic [7:0]            reg_slave_address_i,
  input  logic [7:0]            reg_prescale_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_empty_i,
  output logic                  tx_rd_en_o,
  input  logic                  rx_full_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_wr_en_o,
  input  logic                  sda_i,
  output logic                  sda_oe_o,
  output logic                  scl_oe_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  nack_o
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, TX_WAIT, TX_BYTE,
    TX_ACK, RX_BYTE, RX_ACK, RX_WAIT, STOP
  } state_e;

  state_e                state_q, state_d;
  logic                  go_q, go_d;
  logic [7:0]            pre_q, pre_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            ph_q, ph_d;
  logic [2:0]            bit_q, bit_d;
  logic [3:0]            n_q, n_d;
  logic                  rw_q, rw_d;
  logic                  samp_q, samp_d;
  logic                  nack_q, nack_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  tick, bit_end, run;
  logic                  want_tx, want_rx, rx_last;
  logic                  unused_cmd;

  assign unused_cmd = ^reg_command_i[3:1];
  assign go_d       = reg_command_i[0];
  assign tick       = (cnt_q == 8'd0);
  assign bit_end    = tick && (ph_q == 2'd3);
  assign run        = (state_q != IDLE) &&
                      (state_q != TX_WAIT) &&
                      (state_q != RX_WAIT);

  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign nack_o    = nack_q;
  assign rx_data_o = sh_q;

  // Next-state: tick/phase timing, bit/byte sequencing, FIFO handshakes.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    ph_d       = ph_q;
    bit_d      = bit_q;
    n_d        = n_q;
    rw_d       = rw_q;
    samp_d     = samp_q;
    nack_d     = nack_q;
    done_d     = 1'b0;
    sh_d       = sh_q;
    tx_rd_en_o = 1'b0;
    rx_wr_en_o = 1'b0;
    want_tx    = 1'b0;
    want_rx    = 1'b0;
    rx_last    = 1'b0;
    if (run) begin
      if (tick) begin
        cnt_d = pre_q;
        ph_d  = ph_q + 2'd1;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
      if (tick && ph_q == 2'd1) samp_d = sda_i;
    end
    unique case (state_q)
      IDLE: begin
        if (reg_command_i[0] && !go_q) begin
          state_d = START;
          pre_d   = reg_prescale_i;
          cnt_d   = reg_prescale_i;
          ph_d    = 2'd0;
          n_d     = reg_command_i[7:4];
          rw_d    = reg_slave_address_i[0];
          sh_d    = reg_slave_address_i;
          nack_d  = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = ADDR;
          bit_d   = 3'd7;
        end
      end
      ADDR: begin
        if (bit_end) begin
          if (bit_q == 3'd0) begin
            state_d = ADDR_ACK;
          end else begin
            sh_d  = {sh_q[DATA_WIDTH-2:0], 1'b0};
            bit_d = bit_q - 3'd1;
          end
        end
      end
      ADDR_ACK: begin
        if (bit_end) begin
          if (samp_q) begin
            nack_d  = 1'b1;
            state_d = STOP;
          end else if (n_q == 4'd0) begin
            state_d = STOP;
          end else if (rw_q) begin
            state_d = RX_BYTE;
            bit_d   = 3'd7;
          end else begin
            want_tx = 1'b1;
          end
        end
      end
      TX_WAIT: want_tx = 1'b1;
      TX_BYTE: begin
        if (bit_end) begin
          if (bit_q == 3'd0) begin
            state_d = TX_ACK;
          end else begin
            sh_d  = {sh_q[DATA_WIDTH-2:0], 1'b0};
            bit_d = bit_q - 3'd1;
          end
        end
      end
      TX_ACK: begin
        if (bit_end) begin
          if (samp_q) begin
            nack_d  = 1'b1;
            state_d = STOP;
          end else begin
            n_d = n_q - 4'd1;
            if (n_q == 4'd1) state_d = STOP;
            else             want_tx = 1'b1;
          end
        end
      end
      RX_BYTE: begin
        if (tick && ph_q == 2'd1)
          sh_d = {sh_q[DATA_WIDTH-2:0], sda_i};
        if (bit_end) begin
          if (bit_q == 3'd0) state_d = RX_ACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      RX_ACK: begin
        if (bit_end) begin
          n_d     = n_q - 4'd1;
          want_rx = 1'b1;
          rx_last = (n_q == 4'd1);
        end
      end
      RX_WAIT: begin
        want_rx = 1'b1;
        rx_last = (n_q == 4'd0);
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (want_tx) begin
      if (!tx_empty_i) begin
        tx_rd_en_o = 1'b1;
        sh_d       = tx_data_i;
        bit_d      = 3'd7;
        state_d    = TX_BYTE;
      end else begin
        state_d = TX_WAIT;
      end
    end
    if (want_rx) begin
      if (!rx_full_i) begin
        rx_wr_en_o = 1'b1;
        bit_d      = 3'd7;
        state_d    = rx_last ? STOP : RX_BYTE;
      end else begin
        state_d = RX_WAIT;
      end
    end
  end

  // Bus drive: per-state, per-phase open-drain enables.
  always_comb begin
    scl_oe_o = 1'b0;
    sda_oe_o = 1'b0;
    unique case (state_q)
      START: begin
        sda_oe_o = ph_q[1];
        scl_oe_o = (ph_q == 2'd3);
      end
      ADDR, TX_BYTE: begin
        scl_oe_o = (ph_q == 2'd0) || (ph_q == 2'd3);
        sda_oe_o = ~sh_q[DATA_WIDTH-1];
      end
      ADDR_ACK, TX_ACK, RX_BYTE: begin
        scl_oe_o = (ph_q == 2'd0) || (ph_q == 2'd3);
      end
      RX_ACK: begin
        scl_oe_o = (ph_q == 2'd0) || (ph_q == 2'd3);
        sda_oe_o = (n_q != 4'd1);
      end
      TX_WAIT, RX_WAIT: scl_oe_o = 1'b1;
      STOP: begin
        scl_oe_o = (ph_q == 2'd0);
        sda_oe_o = ~ph_q[1];
      end
      default: begin
        scl_oe_o = 1'b0;
        sda_oe_o = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      state_q <= IDLE;
      go_q    <= 1'b0;
      pre_q   <= '0;
      cnt_q   <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      n_q     <= '0;
      rw_q    <= 1'b0;
      samp_q  <= 1'b0;
      nack_q  <= 1'b0;
      done_q  <= 1'b0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      n_q     <= n_d;
      rw_q    <= rw_d;
      samp_q  <= samp_d;
      nack_q  <= nack_d;
      done_q  <= done_d;
      sh_q    <= sh_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_controller.sv
// tb_i2c_master_controller: scoreboard bench with a behavioural slave.
// Bus bytes, FIFO pops, RX pushes and done pulses are checked in order.
`timescale 1ns/1ps
module tb_i2c_master_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cmd, sla, pre, tx_data, rx_data;
  logic       tx_empty, tx_rd_en, rx_full, rx_wr_en;
  logic       sda_in, sda_oe, scl_oe, busy, done, nack;

  always #5 clk = ~clk;

  i2c_master_controller #(.DATA_WIDTH(8)) dut (
    .pclk_i              (clk),
    .preset_ni           (rst_n),
    .reg_command_i       (cmd),
    .reg_slave_address_i (sla),
    .reg_prescale_i      (pre),
    .tx_data_i           (tx_data),
    .tx_empty_i          (tx_empty),
    .tx_rd_en_o          (tx_rd_en),
    .rx_full_i           (rx_full),
    .rx_data_o           (rx_data),
    .rx_wr_en_o          (rx_wr_en),
    .sda_i               (sda_in),
    .sda_oe_o            (sda_oe),
    .scl_oe_o            (scl_oe),
    .busy_o              (busy),
    .done_o              (done),
    .nack_o              (nack)
  );

  typedef struct packed {
    logic [1:0] kind;
    logic [8:0] data;
  } ev_t;

  localparam logic [1:0] EV_BYTE = 2'd0;
  localparam logic [1:0] EV_POP  = 2'd1;
  localparam logic [1:0] EV_RX   = 2'd2;
  localparam logic [1:0] EV_DONE = 2'd3;

  ev_t        exp_q[$];
  logic [7:0] txf[$];
  int         checks = 0;
  int         errors = 0;
  int         busy_cnt = 0;
  int         done_cnt = 0;
  logic       pop_pend = 1'b0;

  logic       slv_pull = 1'b0;
  logic       addr_ack = 1'b1;
  logic [7:0] rd_bytes [2];
  int         bitn = -1000;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic [7:0] sh = 8'h00;
  logic       rd_mode = 1'b0;

  assign sda_in = ~(sda_oe | slv_pull);

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [8:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [1:0] k, input logic [8:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind %0d data %h expected none",
               k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.data !== d) begin
        errors++;
        $display("FAIL event got kind %0d data %h expected kind %0d data %h",
                 k, d, e.kind, e.data);
      end
    end
  endtask

  task automatic drive_tx();
    tx_empty = (txf.size() == 0);
    tx_data  = tx_empty ? 8'h00 : txf[0];
  endtask

  task automatic wait_done(input int d0, input int lim, input string nm);
    int i;
    i = 0;
    while (done_cnt == d0 && i < lim) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s timeout got no done expected done within %0d",
               nm, lim);
    end
  endtask

  // FIFO model: a pop seen during a cycle takes effect after its edge.
  always @(posedge clk) begin
    if (pop_pend) begin
      #1;
      if (txf.size() != 0) void'(txf.pop_front());
      pop_pend = 1'b0;
      drive_tx();
    end
  end

  // Slave model and output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic scl_l, sda_l;
    int   pos, frame;
    scl_l = ~scl_oe;
    sda_l = sda_in;
    if (rst_n) begin
      if (prev_scl && scl_l && prev_sda && !sda_l) begin
        bitn = -1;
      end else if (!prev_scl && scl_l && bitn >= 0) begin
        pos = bitn % 9;
        if (pos < 8) begin
          sh = {sh[6:0], sda_l};
        end else begin
          if (bitn / 9 == 0) rd_mode = sh[0];
          observe(EV_BYTE, {sda_l, sh});
        end
      end else if (prev_scl && !scl_l) begin
        bitn++;
        pos   = bitn % 9;
        frame = bitn / 9;
        slv_pull = 1'b0;
        if (bitn >= 0) begin
          if (pos == 8 && frame == 0)
            slv_pull = addr_ack;
          else if (pos == 8)
            slv_pull = !rd_mode;
          else if (frame > 0 && frame - 1 < 2 && rd_mode)
            slv_pull = ~rd_bytes[frame-1][7-pos];
        end
      end
      if (busy) busy_cnt++;
      if (tx_rd_en) begin
        observe(EV_POP, 9'h000);
        pop_pend = 1'b1;
      end
      if (rx_wr_en) observe(EV_RX, {1'b0, rx_data});
      if (done) begin
        done_cnt++;
        observe(EV_DONE, {8'h00, nack});
      end
    end
    prev_scl = scl_l;
    prev_sda = sda_l;
  end

  initial begin
    int d0, glitch, i;
    cmd = 8'h00;
    sla = 8'h00;
    pre = 8'h00;
    rx_full = 1'b0;
    rd_bytes[0] = 8'h3C;
    rd_bytes[1] = 8'hC3;
    drive_tx();
    repeat (3) @(negedge clk);
    chk("rst_sda_oe", int'(sda_oe), 0);
    chk("rst_scl_oe", int'(scl_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_nack", int'(nack), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_tx_rd_en", int'(tx_rd_en), 0);
    chk("rst_rx_wr_en", int'(rx_wr_en), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0x50, one byte 0xA5, prescale 0.
    sla = 8'hA0;
    pre = 8'd0;
    txf.push_back(8'hA5);
    drive_tx();
    expect_ev(EV_BYTE, {1'b0, 8'hA0});
    expect_ev(EV_POP, 9'h000);
    expect_ev(EV_BYTE, {1'b0, 8'hA5});
    expect_ev(EV_DONE, 9'h000);
    busy_cnt = 0;
    d0 = done_cnt;
    cmd = 8'h11;
    wait_done(d0, 1000, "wr_done");
    chk("wr_busy_cycles", busy_cnt, 80);
    chk("wr_busy_low_at_done", int'(busy), 0);
    chk("wr_fifo_drained", txf.size(), 0);
    cmd = 8'h00;
    repeat (5) @(negedge clk);
    chk("wr_done_once", done_cnt - d0, 1);
    chk("wr_queue_empty", exp_q.size(), 0);

    // Address NACK on a 3-byte write, prescale 2.
    sla = 8'hA0;
    pre = 8'd2;
    addr_ack = 1'b0;
    txf.push_back(8'h11);
    txf.push_back(8'h22);
    txf.push_back(8'h33);
    drive_tx();
    expect_ev(EV_BYTE, {1'b1, 8'hA0});
    expect_ev(EV_DONE, 9'h001);
    busy_cnt = 0;
    d0 = done_cnt;
    cmd = 8'h31;
    wait_done(d0, 2000, "nack_done");
    chk("nack_busy_cycles", busy_cnt, 132);
    @(negedge clk);
    chk("nack_sticky", int'(nack), 1);
    chk("nack_no_pop", txf.size(), 3);
    cmd = 8'h00;
    addr_ack = 1'b1;
    txf.delete();
    drive_tx();
    repeat (5) @(negedge clk);
    chk("nack_queue_empty", exp_q.size(), 0);

    // Read two bytes, prescale 1; go then held high.
    sla = 8'hA3;
    pre = 8'd1;
    expect_ev(EV_BYTE, {1'b0, 8'hA3});
    expect_ev(EV_BYTE, {1'b0, 8'h3C});
    expect_ev(EV_RX, {1'b0, 8'h3C});
    expect_ev(EV_BYTE, {1'b1, 8'hC3});
    expect_ev(EV_RX, {1'b0, 8'hC3});
    expect_ev(EV_DONE, 9'h000);
    busy_cnt = 0;
    d0 = done_cnt;
    cmd = 8'h21;
    repeat (2) @(negedge clk);
    chk("nack_cleared_on_go", int'(nack), 0);
    chk("rd_busy", int'(busy), 1);
    wait_done(d0, 2000, "rd_done");
    chk("rd_busy_cycles", busy_cnt, 232);
    busy_cnt = 0;
    d0 = done_cnt;
    repeat (200) @(negedge clk);
    chk("go_held_no_busy", busy_cnt, 0);
    chk("go_held_no_done", done_cnt - d0, 0);
    chk("rd_nack", int'(nack), 0);
    chk("rd_queue_empty", exp_q.size(), 0);
    cmd = 8'h00;
    repeat (3) @(negedge clk);

    // Two-byte write, prescale 3, FIFO empty before byte 2.
    sla = 8'hA0;
    pre = 8'd3;
    txf.push_back(8'h5A);
    drive_tx();
    expect_ev(EV_BYTE, {1'b0, 8'hA0});
    expect_ev(EV_POP, 9'h000);
    expect_ev(EV_BYTE, {1'b0, 8'h5A});
    expect_ev(EV_POP, 9'h000);
    expect_ev(EV_BYTE, {1'b0, 8'h96});
    expect_ev(EV_DONE, 9'h000);
    busy_cnt = 0;
    d0 = done_cnt;
    cmd = 8'h21;
    i = 0;
    while (!tx_rd_en && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk("wait_first_pop_seen", int'(tx_rd_en), 1);
    glitch = 0;
    for (int k = 1; k <= 163; k++) begin
      @(negedge clk);
      if (k == 30) cmd = 8'h20;
      if (k == 40) cmd = 8'h21;
      if (k >= 146 && !(scl_oe && !sda_oe)) glitch++;
    end
    @(posedge clk);
    #1;
    txf.push_back(8'h96);
    drive_tx();
    wait_done(d0, 3000, "wait_done");
    chk("wait_scl_held_low", glitch, 0);
    chk("wait_busy_cycles", busy_cnt, 484);
    repeat (100) @(negedge clk);
    chk("toggle_single_done", done_cnt - d0, 1);
    chk("toggle_idle", int'(busy), 0);
    chk("wait_queue_empty", exp_q.size(), 0);
    cmd = 8'h00;
    repeat (3) @(negedge clk);

    // Reset in the middle of the address byte.
    sla = 8'hA0;
    pre = 8'd0;
    txf.push_back(8'hA5);
    drive_tx();
    d0 = done_cnt;
    cmd = 8'h11;
    repeat (10) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    chk("mid_addr_sda_low", int'(sda_oe), 1);
    cmd = 8'h00;
    rst_n = 1'b0;
    bitn = -1000;
    slv_pull = 1'b0;
    #1;
    chk("mid_rst_sda_oe", int'(sda_oe), 0);
    chk("mid_rst_scl_oe", int'(scl_oe), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("post_rst_no_done", done_cnt - d0, 0);
    chk("post_rst_idle", int'(busy), 0);
    chk("post_rst_scl", int'(scl_oe), 0);
    chk("post_rst_no_pop", txf.size(), 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
